// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and types for the elastic MIPS pipeline-stage register.
package pipe_stage_reg_pkg;

    // PC value carried by bubbles and held after reset; the all-zero instruction is a nop.
    localparam logic [31:0] PC_RESET  = 32'h0000_3004;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // D/E payload layout, LSB first: instr, rd1, rd2, rs, rt, rd, ext_imm, pc+8.
    localparam int INSTR_W   = 32;
    localparam int RD1_W     = 32;
    localparam int RD2_W     = 32;
    localparam int REG_W     = 5;
    localparam int IMM_W     = 32;
    localparam int PC8_W     = 32;
    localparam int INSTR_OFS = 0;
    localparam int RD1_OFS   = INSTR_OFS + INSTR_W;
    localparam int RD2_OFS   = RD1_OFS + RD1_W;
    localparam int RS_OFS    = RD2_OFS + RD2_W;
    localparam int RT_OFS    = RS_OFS + REG_W;
    localparam int RD_OFS    = RT_OFS + REG_W;
    localparam int IMM_OFS   = RD_OFS + REG_W;
    localparam int PC8_OFS   = IMM_OFS + IMM_W;
    localparam int DE_DATA_W = PC8_OFS + PC8_W;

    // What the main register loads on an advancing edge.
    typedef enum logic [1:0] {
        ACT_SKID   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_ACCEPT = 2'd2,
        ACT_DRAIN  = 2'd3
    } main_act_e;

    // Number of occupied slots (main + skid), 0..2.
    function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear, used for bubble statistics.
module pipe_stage_reg_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Increment unless already at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: main slot plus one skid slot, with
// hold / bubble-insert / flush controls from the hazard unit.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                 DATA_W      = 32,
    parameter int                 PC_W        = 32,
    parameter logic [PC_W-1:0]    PC_BUBBLE   = PC_W'(PC_RESET),
    parameter logic [DATA_W-1:0]  BUBBLE_DATA = '0,
    parameter int                 CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_bubble,
    input  logic              hold,
    input  logic              bubble,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              main_v_q, main_v_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d;
    logic              main_bub_q, main_bub_d;
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
    logic              acc;
    logic              adv;
    logic              bub_inc;
    main_act_e         act;

    // A full skid, a bubble request or a flush all block new input.
    assign in_ready = !skid_v_q && !bubble && !flush;
    assign acc      = in_valid && in_ready;
    assign adv      = (out_ready && !hold) || !main_v_q;

    // Pick the main-register source on an advancing edge; skid drains first to keep order.
    always_comb begin
        act = ACT_DRAIN;
        if (skid_v_q) begin
            act = ACT_SKID;
        end else if (bubble) begin
            act = ACT_BUBBLE;
        end else if (acc) begin
            act = ACT_ACCEPT;
        end
    end

    // Next-state for main and skid slots.
    always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        main_pc_d   = main_pc_q;
        main_bub_d  = main_bub_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_pc_d   = skid_pc_q;
        bub_inc     = 1'b0;
        if (flush) begin
            main_v_d    = 1'b0;
            main_data_d = BUBBLE_DATA;
            main_pc_d   = PC_BUBBLE;
            main_bub_d  = 1'b0;
            skid_v_d    = 1'b0;
        end else if (adv) begin
            case (act)
                ACT_SKID: begin
                    main_v_d    = 1'b1;
                    main_data_d = skid_data_q;
                    main_pc_d   = skid_pc_q;
                    main_bub_d  = 1'b0;
                    skid_v_d    = 1'b0;
                end
                ACT_BUBBLE: begin
                    main_v_d    = 1'b1;
                    main_data_d = BUBBLE_DATA;
                    main_pc_d   = PC_BUBBLE;
                    main_bub_d  = 1'b1;
                    bub_inc     = 1'b1;
                end
                ACT_ACCEPT: begin
                    main_v_d    = 1'b1;
                    main_data_d = in_data;
                    main_pc_d   = in_pc;
                    main_bub_d  = 1'b0;
                end
                default: begin
                    main_v_d = 1'b0;
                end
            endcase
        end else if (acc) begin
            skid_v_d    = 1'b1;
            skid_data_d = in_data;
            skid_pc_d   = in_pc;
        end
    end

    // Stage registers; reset leaves the stage empty and holding the bubble PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_v_q    <= 1'b0;
            main_data_q <= BUBBLE_DATA;
            main_pc_q   <= PC_BUBBLE;
            main_bub_q  <= 1'b0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_pc_q   <= '0;
        end else begin
            main_v_q    <= main_v_d;
            main_data_q <= main_data_d;
            main_pc_q   <= main_pc_d;
            main_bub_q  <= main_bub_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    pipe_stage_reg_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bub_inc),
        .cnt   (bubble_cnt)
    );

    assign out_valid  = main_v_q;
    assign out_data   = main_data_q;
    assign out_pc     = main_pc_q;
    assign out_bubble = main_bub_q;
    assign occupancy  = occ_count(main_v_q, skid_v_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: expected tokens are queued as the
// bench drives them, and a monitor queues tokens the DUT hands downstream.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int CNT_W  = 4;
    localparam logic [31:0] BPC = 32'h0000_3004;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
        logic              bub;
    } tok_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [PC_W-1:0]   in_pc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [PC_W-1:0]   out_pc;
    logic              out_bubble;
    logic              hold = 1'b0;
    logic              bubble = 1'b0;
    logic              flush = 1'b0;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  bubble_cnt;

    tok_t exp_q[$];
    tok_t obs_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_pc     (out_pc),
        .out_bubble (out_bubble),
        .hold       (hold),
        .bubble     (bubble),
        .flush      (flush),
        .occupancy  (occupancy),
        .bubble_cnt (bubble_cnt)
    );

    // Downstream monitor: a token leaves when valid and accepted at the edge.
    always @(posedge clk) begin
        if (!reset && !flush && out_valid && out_ready && !hold)
            obs_q.push_back('{pc: out_pc, data: out_data, bub: out_bubble});
    end

    function automatic logic [DATA_W-1:0] data_of(input logic [PC_W-1:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PC_W-1:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_data  = data_of(pc);
    endtask

    // Compares everything delivered so far against what was queued, then empties both.
    task automatic drain_scoreboard(input string name);
        n_checks++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL %s token count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
        else
            n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            tok_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e)
                $display("FAIL %s token: got pc=%h data=%h bub=%b expected pc=%h data=%h bub=%b",
                         name, o.pc, o.data, o.bub, e.pc, e.data, e.bub);
            else
                n_pass++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; out_ready = 1'b1;
        send(32'h3000);
        tick(); tick();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (out_pc !== BPC) $display("FAIL reset out_pc: got %h expected %h", out_pc, BPC); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL reset out_data: got %h expected 0", out_data); else n_pass++;
        n_checks++; if (occupancy !== 2'd0) $display("FAIL reset occupancy: got %0d expected 0", occupancy); else n_pass++;
        n_checks++; if (bubble_cnt !== '0) $display("FAIL reset bubble_cnt: got %0d expected 0", bubble_cnt); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b expected 1", in_ready); else n_pass++;
        n_checks++; if (out_bubble !== 1'b0) $display("FAIL reset out_bubble: got %b expected 0", out_bubble); else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_streaming();
        logic [PC_W-1:0] pcs [3];
        pcs = '{32'h3000, 32'h3004, 32'h3008};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(pcs[i]);
            exp_q.push_back('{pc: pcs[i], data: data_of(pcs[i]), bub: 1'b0});
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_pc !== pcs[i])
                $display("FAIL stream out[%0d]: got v=%b pc=%h expected v=1 pc=%h", i, out_valid, out_pc, pcs[i]); else n_pass++;
            n_checks++; if (occupancy !== 2'd1) $display("FAIL stream occupancy[%0d]: got %0d expected 1", i, occupancy); else n_pass++;
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL stream drained out_valid: got %b expected 0", out_valid); else n_pass++;
        drain_scoreboard("stream");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(32'h3000);
        exp_q.push_back('{pc: 32'h3000, data: data_of(32'h3000), bub: 1'b0});
        tick();
        send(32'h3004);
        exp_q.push_back('{pc: 32'h3004, data: data_of(32'h3004), bub: 1'b0});
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (out_pc !== 32'h3000) $display("FAIL bp held pc: got %h expected 3000", out_pc); else n_pass++;
        n_checks++; if (occupancy !== 2'd2) $display("FAIL bp occupancy: got %0d expected 2", occupancy); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp in_ready full: got %b expected 0", in_ready); else n_pass++;
        tick();
        n_checks++; if (out_pc !== 32'h3000 || occupancy !== 2'd2)
            $display("FAIL bp stall: got pc=%h occ=%0d expected pc=3000 occ=2", out_pc, occupancy); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_pc !== 32'h3004 || out_valid !== 1'b1)
            $display("FAIL bp release: got v=%b pc=%h expected v=1 pc=3004", out_valid, out_pc); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp in_ready release: got %b expected 1", in_ready); else n_pass++;
        tick();
        drain_scoreboard("backpressure");
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        bubble = 1'b1;
        send(32'h3010);
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bubble in_ready: got %b expected 0", in_ready); else n_pass++;
        exp_q.push_back('{pc: BPC, data: '0, bub: 1'b1});
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_bubble !== 1'b1 || out_data !== '0 || out_pc !== BPC)
            $display("FAIL bubble token: got v=%b bub=%b data=%h pc=%h expected v=1 bub=1 data=0 pc=3004",
                     out_valid, out_bubble, out_data, out_pc); else n_pass++;
        n_checks++; if (bubble_cnt !== 4'd1) $display("FAIL bubble count: got %0d expected 1", bubble_cnt); else n_pass++;
        bubble = 1'b0;
        exp_q.push_back('{pc: 32'h3010, data: data_of(32'h3010), bub: 1'b0});
        tick();
        n_checks++; if (out_pc !== 32'h3010 || out_bubble !== 1'b0)
            $display("FAIL bubble follow: got pc=%h bub=%b expected pc=3010 bub=0", out_pc, out_bubble); else n_pass++;
        in_valid = 1'b0;
        tick();
        drain_scoreboard("bubble");
    endtask

    task automatic test_hold();
        out_ready = 1'b1;
        send(32'h3020);
        exp_q.push_back('{pc: 32'h3020, data: data_of(32'h3020), bub: 1'b0});
        tick();
        hold = 1'b1;
        send(32'h3024);
        exp_q.push_back('{pc: 32'h3024, data: data_of(32'h3024), bub: 1'b0});
        tick();
        send(32'h3028);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3020 || occupancy !== 2'd2 || in_ready !== 1'b0)
                $display("FAIL hold frozen[%0d]: got v=%b pc=%h occ=%0d rdy=%b expected v=1 pc=3020 occ=2 rdy=0",
                         i, out_valid, out_pc, occupancy, in_ready); else n_pass++;
            if (i < 2) tick();
        end
        hold = 1'b0;
        exp_q.push_back('{pc: 32'h3028, data: data_of(32'h3028), bub: 1'b0});
        tick();
        n_checks++; if (out_pc !== 32'h3024 || occupancy !== 2'd1)
            $display("FAIL hold release: got pc=%h occ=%0d expected pc=3024 occ=1", out_pc, occupancy); else n_pass++;
        tick();
        n_checks++; if (out_pc !== 32'h3028) $display("FAIL hold next: got pc=%h expected 3028", out_pc); else n_pass++;
        in_valid = 1'b0;
        tick();
        drain_scoreboard("hold");
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send(32'h3030); tick();
        send(32'h3034); tick();
        n_checks++; if (occupancy !== 2'd2) $display("FAIL flush prefill occupancy: got %0d expected 2", occupancy); else n_pass++;
        flush = 1'b1;
        send(32'h3038);
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL flush in_ready: got %b expected 0", in_ready); else n_pass++;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
            $display("FAIL flush empty: got v=%b occ=%0d expected v=0 occ=0", out_valid, occupancy); else n_pass++;
        n_checks++; if (out_pc !== BPC || out_data !== '0)
            $display("FAIL flush bubble values: got pc=%h data=%h expected pc=3004 data=0", out_pc, out_data); else n_pass++;
        n_checks++; if (bubble_cnt !== 4'd1) $display("FAIL flush bubble_cnt: got %0d expected 1", bubble_cnt); else n_pass++;
        out_ready = 1'b1;
        tick(); tick();
        drain_scoreboard("flush");
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        bubble = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back('{pc: BPC, data: '0, bub: 1'b1});
            tick();
        end
        bubble = 1'b0;
        n_checks++; if (bubble_cnt !== 4'hF) $display("FAIL saturate bubble_cnt: got %0d expected 15", bubble_cnt); else n_pass++;
        tick();
        n_checks++; if (bubble_cnt !== 4'hF) $display("FAIL saturate stable: got %0d expected 15", bubble_cnt); else n_pass++;
        drain_scoreboard("saturate");
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_hold();
        test_flush();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
